// File: rtl/prog_counter.sv
// prog_counter: program counter and fetch sequencer with run/halt control.
// Optional return stack enabled by defining PC_CALL_STACK_EN.
module prog_counter #(
    parameter int PC_W  = 10,
    parameter int STK_D = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            JumpEn,
    input  logic [5:0]      Jump,
    input  logic            Call,
    input  logic            Ret,
    input  logic            HaltReq,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running,
    output logic            Done,
    output logic            Err
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            fault;
    logic            bad_tgt;
    logic [PC_W-1:0] jump_pc;

    assign bad_tgt = (Jump == 6'h3F);
    assign jump_pc = PC_W'(Jump);

`ifdef PC_CALL_STACK_EN
    localparam int SP_W = $clog2(STK_D + 1);
    localparam int IW   = (STK_D > 1) ? $clog2(STK_D) : 1;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [PC_W-1:0] stk_q [STK_D];
    logic [PC_W-1:0] stk_d [STK_D];
`else
    localparam int unused_stk_d = STK_D;
    logic unused_ret;
    assign unused_ret = Ret;
`endif

    // Next-state, next-PC and stack update for one fetch cycle
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        err_d   = err_q;
        fault   = 1'b0;
`ifdef PC_CALL_STACK_EN
        sp_d    = sp_q;
        stk_d   = stk_q;
`endif
        if (state_q != RUN) begin
            if (Start) begin
                state_d = RUN;
                pc_d    = '0;
                done_d  = 1'b0;
                err_d   = 1'b0;
`ifdef PC_CALL_STACK_EN
                sp_d    = '0;
`endif
            end
        end else if (!Stall) begin
            if (HaltReq) begin
                state_d = HALT;
                done_d  = 1'b1;
            end
`ifdef PC_CALL_STACK_EN
            else if (Ret) begin
                if (sp_q == '0) fault = 1'b1;
                else begin
                    pc_d = stk_q[IW'(sp_q - SP_W'(1))];
                    sp_d = sp_q - SP_W'(1);
                end
            end else if (Call) begin
                if (bad_tgt || sp_q == SP_W'(STK_D)) fault = 1'b1;
                else begin
                    stk_d[IW'(sp_q)] = pc_q + PC_W'(1);
                    sp_d = sp_q + SP_W'(1);
                    pc_d = jump_pc;
                end
            end else if (JumpEn) begin
                if (bad_tgt) fault = 1'b1;
                else pc_d = jump_pc;
            end
`else
            else if (Call || JumpEn) begin
                if (bad_tgt) fault = 1'b1;
                else pc_d = jump_pc;
            end
`endif
            else if (pc_q == '1) fault = 1'b1;
            else pc_d = pc_q + PC_W'(1);
            if (fault) begin
                state_d = HALT;
                err_d   = 1'b1;
            end
        end
        running_d = (state_d == RUN);
    end

    // Register all state and outputs; reset clears everything including the stack
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PC_CALL_STACK_EN
            sp_q      <= '0;
            stk_q     <= '{default: '0};
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef PC_CALL_STACK_EN
            sp_q      <= sp_d;
            stk_q     <= stk_d;
`endif
        end
    end

    assign ProgCtr = pc_q;
    assign Running = running_q;
    assign Done    = done_q;
    assign Err     = err_q;
endmodule
